// File: rtl/mano_pkg.sv
// Shared types for the Mano-style instruction sequencer: state encoding,
// opcode values and the width of the per-instruction timing count.
package mano_pkg;

  localparam int T_W = 3;

  localparam logic [1:0] OP_HLT = 2'b00;
  localparam logic [1:0] OP_LDA = 2'b01;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // PAUSE is reachable only in single-step builds.
  typedef enum logic [3:0] {
    IDLE, F_ADDR, F_READ, F_LDIR, DECODE,
    X_ADDR, X_READ, X_LDA, X_MOV, HALT, ERROR, PAUSE
  } state_e;

  function automatic logic is_read(state_e s);
    return (s == F_READ) || (s == X_READ);
  endfunction

endpackage

// File: rtl/mano_wait_timer.sv
// Memory-wait watchdog: counts stalled read cycles and flags the cycle in
// which the TIMEOUT_CYCLES-th consecutive stall occurs.
module mano_wait_timer
  import mano_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (count_en && !expired)
      count <= count + CW'(1);
  end

  assign expired = count_en && (count == LAST);

endmodule

// File: rtl/mano_sequencer.sv
// Control sequencer for a small accumulator machine (fetch/decode/execute).
// Define MANO_SEQ_SSTEP_EN to pause after each instruction until step=1.
module mano_sequencer
  import mano_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cycle_en,
  input  logic           start,
  input  logic           step,
  input  logic [1:0]     opcode,
  input  logic           mem_ack,
  output logic           ld_mar_pc,
  output logic           ld_mar_mbr,
  output logic           inc_pc,
  output logic           ld_mbr,
  output logic           ld_ir,
  output logic           ld_a_mbr,
  output logic           ld_a_r,
  output logic           mem_req,
  output logic [T_W-1:0] t_state,
  output logic           busy,
  output logic           halted,
  output logic           err
);

`ifdef MANO_SEQ_SSTEP_EN
  localparam state_e INSTR_DONE = PAUSE;
`else
  localparam state_e INSTR_DONE = F_ADDR;
`endif

  state_e         state, state_nxt;
  logic [T_W-1:0] t_q;
  logic           wait_cnt_en, wait_clear, wait_expired;

  assign wait_cnt_en = cycle_en && is_read(state) && !mem_ack;
  assign wait_clear  = cycle_en && !wait_cnt_en;

  mano_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (wait_clear),
    .count_en (wait_cnt_en),
    .expired  (wait_expired)
  );

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt  = state;
    ld_mar_pc  = 1'b0;
    ld_mar_mbr = 1'b0;
    inc_pc     = 1'b0;
    ld_mbr     = 1'b0;
    ld_ir      = 1'b0;
    ld_a_mbr   = 1'b0;
    ld_a_r     = 1'b0;
    mem_req    = 1'b0;
    // Reset suppresses strobes in its own cycle, so an ack racing it is dropped.
    if (cycle_en && !rst) begin
      unique case (state)
        IDLE:   if (start) state_nxt = F_ADDR;
        F_ADDR: begin
          ld_mar_pc = 1'b1;
          state_nxt = F_READ;
        end
        F_READ: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ld_mbr    = 1'b1;
            inc_pc    = 1'b1;
            state_nxt = F_LDIR;
          end else if (wait_expired) begin
            state_nxt = ERROR;
          end
        end
        F_LDIR: begin
          ld_ir     = 1'b1;
          state_nxt = DECODE;
        end
        DECODE: begin
          unique case (opcode)
            OP_HLT:  state_nxt = HALT;
            OP_LDA:  state_nxt = X_ADDR;
            OP_MOV:  state_nxt = X_MOV;
            default: state_nxt = INSTR_DONE;
          endcase
        end
        X_ADDR: begin
          ld_mar_mbr = 1'b1;
          state_nxt  = X_READ;
        end
        X_READ: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ld_mbr    = 1'b1;
            state_nxt = X_LDA;
          end else if (wait_expired) begin
            state_nxt = ERROR;
          end
        end
        X_LDA: begin
          ld_a_mbr  = 1'b1;
          state_nxt = INSTR_DONE;
        end
        X_MOV: begin
          ld_a_r    = 1'b1;
          state_nxt = INSTR_DONE;
        end
        HALT:    if (start) state_nxt = F_ADDR;
        PAUSE:   if (step) state_nxt = F_ADDR;
        ERROR:   state_nxt = ERROR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t_q   <= '0;
    end else begin
      state <= state_nxt;
      if (cycle_en && (state_nxt != state)) begin
        if (state_nxt == F_ADDR)
          t_q <= '0;
        else if (t_q != '1)
          t_q <= t_q + 1'b1;
      end
    end
  end

  assign t_state = t_q;
  assign busy    = !((state == IDLE) || (state == HALT) || (state == ERROR));
  assign halted  = (state == HALT) || (state == ERROR);
  assign err     = (state == ERROR);

endmodule

// File: tb/tb_mano_sequencer.sv
// Self-checking bench for mano_sequencer: an instruction-level model expands
// each instruction into its expected per-enabled-cycle output trace.
module tb_mano_sequencer;
  import mano_pkg::*;

`ifdef MANO_SEQ_SSTEP_EN
  localparam bit SSTEP = 1'b1;
`else
  localparam bit SSTEP = 1'b0;
`endif

  localparam logic [6:0] STB_MARPC  = 7'b1000000;
  localparam logic [6:0] STB_MARMBR = 7'b0100000;
  localparam logic [6:0] STB_INCPC  = 7'b0010000;
  localparam logic [6:0] STB_MBR    = 7'b0001000;
  localparam logic [6:0] STB_IR     = 7'b0000100;
  localparam logic [6:0] STB_AMBR   = 7'b0000010;
  localparam logic [6:0] STB_AR     = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst, cycle_en, start, step, mem_ack;
  logic [1:0] opcode;
  logic       ld_mar_pc, ld_mar_mbr, inc_pc, ld_mbr, ld_ir, ld_a_mbr, ld_a_r;
  logic       mem_req, busy, halted, err;
  logic [2:0] t_state;

  always #5 clk = ~clk;

  mano_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .cycle_en   (cycle_en),
    .start      (start),
    .step       (step),
    .opcode     (opcode),
    .mem_ack    (mem_ack),
    .ld_mar_pc  (ld_mar_pc),
    .ld_mar_mbr (ld_mar_mbr),
    .inc_pc     (inc_pc),
    .ld_mbr     (ld_mbr),
    .ld_ir      (ld_ir),
    .ld_a_mbr   (ld_a_mbr),
    .ld_a_r     (ld_a_r),
    .mem_req    (mem_req),
    .t_state    (t_state),
    .busy       (busy),
    .halted     (halted),
    .err        (err)
  );

  // One entry per enabled machine cycle: expected outputs plus inputs to drive.
  typedef struct {
    logic [6:0] strb;
    logic       mreq, busy, halted, err;
    logic [2:0] t;
    logic       ack, start, step;
    logic [1:0] op;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pos = 0;        // 0: idle, 1: halted, 2: next cycle is a fetch
  int   en_mode = 0;    // 0: random with en_pct, 1: one cycle in four
  int   en_pct = 100;
  int   cyc_i = 0;
  int   read_mark = -1;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] rop();
    return 2'($urandom_range(0, 3));
  endfunction

  function automatic logic [13:0] observed();
    return {ld_mar_pc, ld_mar_mbr, inc_pc, ld_mbr, ld_ir, ld_a_mbr, ld_a_r,
            mem_req, busy, halted, err, t_state};
  endfunction

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic add(input logic [6:0] s, input logic mr, input logic b, input logic h,
                     input logic er, input logic [2:0] t, input logic ack,
                     input logic st, input logic sp, input logic [1:0] op);
    exp_t e;
    e.strb = s; e.mreq = mr; e.busy = b; e.halted = h; e.err = er; e.t = t;
    e.ack = ack; e.start = st; e.step = sp; e.op = op;
    q.push_back(e);
  endtask

  // Leave IDLE or HALT (a few idle cycles first), or fall straight into fetch.
  task automatic add_launch();
    int k;
    k = $urandom_range(0, 2);
    if (pos == 0) begin
      repeat (k) add(7'b0, 0, 0, 0, 0, 3'd0, rbit(), 1'b0, rbit(), rop());
      add(7'b0, 0, 0, 0, 0, 3'd0, rbit(), 1'b1, rbit(), rop());
    end else if (pos == 1) begin
      repeat (k) add(7'b0, 0, 0, 1, 0, 3'd4, rbit(), 1'b0, rbit(), rop());
      add(7'b0, 0, 0, 1, 0, 3'd4, rbit(), 1'b1, rbit(), rop());
    end
  endtask

  task automatic build_instr(input logic [1:0] op, input int d1, input int d2);
    logic [2:0] t_end;
    int k;
    add_launch();
    add(STB_MARPC, 0, 1, 0, 0, 3'd0, rbit(), rbit(), rbit(), rop());
    repeat (d1) add(7'b0, 1, 1, 0, 0, 3'd1, 1'b0, rbit(), rbit(), rop());
    add(STB_MBR | STB_INCPC, 1, 1, 0, 0, 3'd1, 1'b1, rbit(), rbit(), rop());
    add(STB_IR, 0, 1, 0, 0, 3'd2, rbit(), rbit(), rbit(), rop());
    add(7'b0, 0, 1, 0, 0, 3'd3, rbit(), rbit(), rbit(), op);
    t_end = 3'd4;
    case (op)
      OP_LDA: begin
        add(STB_MARMBR, 0, 1, 0, 0, 3'd4, rbit(), rbit(), rbit(), rop());
        for (int i = 0; i < d2; i++) begin
          if (i == 3) read_mark = q.size();
          add(7'b0, 1, 1, 0, 0, 3'd5, 1'b0, rbit(), rbit(), rop());
        end
        add(STB_MBR, 1, 1, 0, 0, 3'd5, 1'b1, rbit(), rbit(), rop());
        add(STB_AMBR, 0, 1, 0, 0, 3'd6, rbit(), rbit(), rbit(), rop());
        t_end = 3'd7;
      end
      OP_MOV: begin
        add(STB_AR, 0, 1, 0, 0, 3'd4, rbit(), rbit(), rbit(), rop());
        t_end = 3'd5;
      end
      default: t_end = 3'd4;
    endcase
    if (op == OP_HLT) begin
      pos = 1;
    end else begin
      if (SSTEP) begin
        k = $urandom_range(1, 3);
        repeat (k) add(7'b0, 0, 1, 0, 0, t_end, rbit(), rbit(), 1'b0, rop());
        add(7'b0, 0, 1, 0, 0, t_end, rbit(), rbit(), 1'b1, rop());
      end
      pos = 2;
    end
  endtask

  // Fetch read that never completes: 15 stalled cycles, then a sticky error.
  task automatic build_timeout();
    add_launch();
    add(STB_MARPC, 0, 1, 0, 0, 3'd0, rbit(), rbit(), rbit(), rop());
    repeat (15) add(7'b0, 1, 1, 0, 0, 3'd1, 1'b0, rbit(), rbit(), rop());
    repeat (5) add(7'b0, 0, 0, 1, 1, 3'd2, rbit(), 1'b1, rbit(), rop());
  endtask

  task automatic run_queue(input int stop_at, input string tag);
    bit   en;
    exp_t e;
    while (q.size() > stop_at) begin
      e  = q[0];
      en = (en_mode == 1) ? ((cyc_i % 4) == 0) : ($urandom_range(0, 99) < en_pct);
      cyc_i++;
      rst    = 1'b0;
      opcode = e.op;
      if (en) begin
        cycle_en = 1'b1; start = e.start; step = e.step; mem_ack = e.ack;
      end else begin
        cycle_en = 1'b0; start = rbit(); step = rbit(); mem_ack = rbit();
      end
      @(negedge clk);
      check(tag, observed(),
            {(en ? e.strb : 7'b0), (en & e.mreq), e.busy, e.halted, e.err, e.t});
      @(posedge clk); #1;
      if (en) void'(q.pop_front());
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; cycle_en = rbit(); start = rbit(); step = rbit(); mem_ack = rbit();
    @(posedge clk); #1;
    cycle_en = rbit(); start = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    check(tag, observed(), 14'b0);
    @(posedge clk); #1;
    rst = 1'b0; cycle_en = 1'b0;
    q.delete();
    pos = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cycle_en = 1'b0; start = 1'b0; step = 1'b0; mem_ack = 1'b0;
    opcode = 2'b00;
    @(posedge clk); #1;
    do_reset("reset_state");

    build_instr(OP_NOP, 0, 0); run_queue(0, "nop_min");
    build_instr(OP_LDA, 3, 3); run_queue(0, "lda_wait3");
    build_instr(OP_MOV, 0, 0); run_queue(0, "mov_min");
    build_instr(OP_HLT, 1, 0); run_queue(0, "halt");
    build_instr(OP_NOP, 0, 0); run_queue(0, "restart_from_halt");
    build_instr(OP_LDA, 14, 14); run_queue(0, "ack_at_last_wait");

    en_pct = 50;
    for (int i = 0; i < 25; i++) begin
      build_instr(rop(), $urandom_range(0, 5), $urandom_range(0, 5));
      run_queue(0, "random");
    end

    en_mode = 1;
    build_instr(OP_MOV, 1, 0);
    build_instr(OP_LDA, 2, 1);
    run_queue(0, "en_quarter");

    read_mark = -1;
    build_instr(OP_LDA, 0, 10);
    run_queue(q.size() - read_mark, "to_x_read");
    rst = 1'b1; cycle_en = 1'b1; mem_ack = 1'b1; start = 1'b0;
    @(negedge clk);
    check("rst_ack_no_ld_mbr", {13'b0, ld_mbr}, 14'b0);
    @(posedge clk); #1;
    rst = 1'b0; cycle_en = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    check("rst_drops_mem_req", observed(), 14'b0);
    @(posedge clk); #1;
    q.delete();
    pos = 0;

    en_mode = 0; en_pct = 70;
    build_instr(OP_LDA, 14, 14); run_queue(0, "wait_cleared_by_rst");

    build_timeout(); run_queue(0, "timeout");
    do_reset("error_reset");
    build_instr(OP_NOP, 0, 0); run_queue(0, "after_error");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mano_sequencer.md
MANO_SEQUENCER -- requirements
Module: mano_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, the maximum cycle_en-qualified wait for mem_ack per read.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port cycle_en, input, 1, machine-cycle tick; all state changes and strobes are qualified by it.
REQ-005 SHALL have port start, input, 1, leave IDLE/HALT and fetch.
REQ-006 SHALL have port step, input, 1, single-step release (used only under REQ-030).
REQ-007 SHALL have port opcode, input, 2, IR[1:0], valid from the cycle after ld_ir.
REQ-008 SHALL have port mem_ack, input, 1, read data valid on the MBR input this cycle.
REQ-009 SHALL have outputs ld_mar_pc, ld_mar_mbr, inc_pc, ld_mbr, ld_ir, ld_a_mbr, ld_a_r, each 1 bit, single-cycle datapath strobes.
REQ-010 SHALL have outputs mem_req (1), t_state (3, timing count within the instruction), busy (1), halted (1), err (1).

Function
REQ-011 SHALL implement states IDLE, F_ADDR, F_READ, F_LDIR, DECODE, X_ADDR, X_READ, X_LDA, X_MOV, HALT, ERROR.
REQ-012 SHALL transition only in cycles with cycle_en=1; strobes and mem_req SHALL be 0 when cycle_en=0.
REQ-013 IDLE: start=1 -> F_ADDR; F_ADDR: assert ld_mar_pc -> F_READ.
REQ-014 F_READ/X_READ: assert mem_req; on mem_ack=1 assert ld_mbr, and additionally inc_pc in F_READ only; then go to F_LDIR or X_LDA respectively.
REQ-015 F_LDIR: assert ld_ir -> DECODE.
REQ-016 DECODE: opcode 00 -> HALT; 01 (LDA) -> X_ADDR; 10 (MOV) -> X_MOV; 11 (NOP) -> F_ADDR.
REQ-017 X_ADDR: assert ld_mar_mbr -> X_READ; X_LDA: assert ld_a_mbr -> F_ADDR; X_MOV: assert ld_a_r -> F_ADDR.
REQ-018 Minimum instruction lengths with mem_ack in the first read cycle: NOP 4, MOV 5, LDA 7 enabled cycles.
REQ-019 t_state SHALL be 0 in F_ADDR, increment each enabled cycle that changes state, hold during memory wait, saturate at 7.
REQ-020 At most one ld_mar_* and at most one ld_a_* strobe SHALL be high in any cycle.
REQ-021 A wait counter SHALL count enabled cycles in a read state without mem_ack; reaching TIMEOUT_CYCLES SHALL enter ERROR, drop mem_req, and set err.
REQ-022 mem_ack outside read states SHALL be ignored; start outside IDLE/HALT SHALL be ignored.
REQ-023 HALT: halted=1; start=1 -> F_ADDR (PC is not reset).
REQ-024 ERROR SHALL be left only by rst; err and halted SHALL both be 1 there.
REQ-025 busy SHALL be 1 in every state except IDLE, HALT, ERROR.

Reset
REQ-026 rst=1 SHALL force IDLE, t_state=0, wait counter=0, and all strobes, mem_req, busy, halted, err to 0 on the next edge, regardless of cycle_en.
REQ-027 Reset during a read SHALL drop mem_req the following cycle, and a simultaneous mem_ack SHALL produce no ld_mbr.
REQ-028 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-029 Macro MANO_SEQ_SSTEP_EN SHALL select single-step mode.
REQ-030 With the macro defined, completing an instruction (the state that would enter F_ADDR) SHALL instead wait in a pause condition with busy=1 until step=1 in an enabled cycle, then go to F_ADDR; without it, step SHALL be ignored and execution SHALL be free-running.

Structure
REQ-031 A shared package mano_pkg SHALL hold the state enum, the opcode constants (HLT=00, LDA=01, MOV=10, NOP=11), and the timing-count width.
REQ-032 The wait/timeout counter SHALL be a sub-module mano_wait_timer (clear, count_en, expired).

Verification
REQ-033 cycle_en=1, start pulse, opcode=11, mem_ack in the first F_READ cycle -> ld_mar_pc, ld_mbr+inc_pc, ld_ir, then ld_mar_pc again exactly 4 cycles later.
REQ-034 opcode=01, mem_ack delayed 3 cycles on each read -> mem_req held 4 cycles per read, ld_mar_mbr then ld_a_mbr, t_state holds during wait, total 13 cycles.
REQ-035 opcode=00 -> halted=1, busy=0 after DECODE; later start pulse -> ld_mar_pc next cycle.
REQ-036 mem_ack never asserted -> err=1 after 15 enabled F_READ cycles; start ignored; rst clears to IDLE.
REQ-037 cycle_en toggling 1-of-4 -> same strobe sequence stretched 4x, no strobe in disabled cycles; rst asserted mid X_READ -> mem_req=0 next cycle.
REQ-038 With MANO_SEQ_SSTEP_EN, MOV instruction -> ld_a_r, then no ld_mar_pc until step=1, then ld_mar_pc in the next cycle.
